// File: rtl/fp_unpack_norm_if.sv
// ---------------------------------------------------------------------------
// fp_unpack_norm_if
// Operand/result bundle for fp_unpack_norm.
//   in_valid / in_ready   : operand handshake (producer -> unpacker)
//   fp[63:0], db          : packed operand and precision select
//   out_valid / out_ready : result handshake (unpacker -> datapath)
//   s, e[12:0], f[52:0]   : sign, unbiased exponent, significand (f[52] = J bit)
//   zero/inf/nan/snan/denorm : operand classification flags
// Modports: slave = the unpacker, master = the block feeding/consuming it.
// ---------------------------------------------------------------------------
interface fp_unpack_norm_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] fp;
    logic        db;
    logic        out_valid;
    logic        out_ready;
    logic        s;
    logic [12:0] e;
    logic [52:0] f;
    logic        zero;
    logic        inf;
    logic        nan;
    logic        snan;
    logic        denorm;

    modport slave (
        input  in_valid, fp, db, out_ready,
        output in_ready, out_valid, s, e, f, zero, inf, nan, snan, denorm
    );

    modport master (
        output in_valid, fp, db, out_ready,
        input  in_ready, out_valid, s, e, f, zero, inf, nan, snan, denorm
    );
endinterface

// File: rtl/fp_unpack_norm.sv
// ---------------------------------------------------------------------------
// fp_unpack_norm
// Unpacks an IEEE single/double operand into the FPU's internal factored
// form: sign, unbiased 13-bit two's complement exponent and a 53-bit
// significand with explicit integer bit. Denormals are normalized by an
// iterative left shifter that moves up to SHIFT_STEP bits per cycle.
//
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : fp_unpack_norm_if.slave (operand in, unpacked result out)
//
// Parameters:
//   SHIFT_STEP : maximum left-shift distance per NORM cycle (1..16)
//
// Build option:
//   UNPACK_FTZ_EN : when defined, denormal operands are flushed to signed
//                   zero (zero=1, denorm=1) instead of being normalized.
//
// State  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for an operand, in_ready=1
// NORM   | shifting a denormal significand left until f[52]=1
// DONE   | result presented, out_valid=1, held until out_ready
// ---------------------------------------------------------------------------
module fp_unpack_norm #(
    parameter int SHIFT_STEP = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    fp_unpack_norm_if.slave  bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] NORM = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [4:0] STEP = 5'(SHIFT_STEP);

    logic [1:0]  state_q;
    logic        s_q;
    logic [12:0] e_q;
    logic [52:0] f_q;
    logic        zero_q;
    logic        inf_q;
    logic        nan_q;
    logic        snan_q;
    logic        denorm_q;

    // ------------------------------------------------------------------
    // Field extraction; both formats are mapped onto double-width fields
    // so classification below is format independent.
    // ------------------------------------------------------------------
    logic        sgn_in;
    logic [51:0] frac_in;
    logic        exp_zero;
    logic        exp_max;
    logic        frac_zero;
    logic [12:0] e_norm;
    logic [12:0] e_denorm;

    always_comb begin
        if (bus.db) begin
            sgn_in   = bus.fp[63];
            frac_in  = bus.fp[51:0];
            exp_zero = (bus.fp[62:52] == 11'd0);
            exp_max  = &bus.fp[62:52];
            e_norm   = {2'b00, bus.fp[62:52]} - 13'd1023;
            e_denorm = 13'd1 - 13'd1023;
        end else begin
            sgn_in   = bus.fp[31];
            frac_in  = {bus.fp[22:0], 29'b0};
            exp_zero = (bus.fp[30:23] == 8'd0);
            exp_max  = &bus.fp[30:23];
            e_norm   = {5'b00000, bus.fp[30:23]} - 13'd127;
            e_denorm = 13'd1 - 13'd127;
        end
        frac_zero = (frac_in == 52'd0);
    end

    // ------------------------------------------------------------------
    // Leading-zero count over the top SHIFT_STEP significand bits.
    // lz == STEP means the whole window is zero and a full step is taken.
    // ------------------------------------------------------------------
    logic [4:0] lz;
    logic       lz_found;

    always_comb begin
        lz       = STEP;
        lz_found = 1'b0;
        for (int i = 0; i < SHIFT_STEP; i++) begin
            if (!lz_found && f_q[52-i]) begin
                lz       = 5'(i);
                lz_found = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            s_q      <= 1'b0;
            e_q      <= 13'd0;
            f_q      <= 53'd0;
            zero_q   <= 1'b0;
            inf_q    <= 1'b0;
            nan_q    <= 1'b0;
            snan_q   <= 1'b0;
            denorm_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        s_q      <= sgn_in;
                        zero_q   <= 1'b0;
                        inf_q    <= 1'b0;
                        nan_q    <= 1'b0;
                        snan_q   <= 1'b0;
                        denorm_q <= 1'b0;
                        if (!exp_zero && !exp_max) begin
                            e_q     <= e_norm;
                            f_q     <= {1'b1, frac_in};
                            state_q <= DONE;
                        end else if (exp_zero && frac_zero) begin
                            e_q     <= 13'd0;
                            f_q     <= 53'd0;
                            zero_q  <= 1'b1;
                            state_q <= DONE;
                        end else if (exp_max) begin
                            e_q     <= 13'd0;
                            f_q     <= {1'b0, frac_in};
                            if (frac_zero) begin
                                inf_q <= 1'b1;
                            end else begin
                                nan_q  <= 1'b1;
                                // quiet bit is the MSB of the fraction
                                snan_q <= ~frac_in[51];
                            end
                            state_q <= DONE;
                        end else begin
`ifdef UNPACK_FTZ_EN
                            e_q      <= 13'd0;
                            f_q      <= 53'd0;
                            zero_q   <= 1'b1;
                            denorm_q <= 1'b1;
                            state_q  <= DONE;
`else
                            e_q      <= e_denorm;
                            f_q      <= {1'b0, frac_in};
                            denorm_q <= 1'b1;
                            state_q  <= NORM;
`endif
                        end
                    end
                end

                NORM: begin
                    // Exponent floor is -1074, well inside 13-bit range.
                    f_q <= f_q << lz;
                    e_q <= e_q - {8'd0, lz};
                    if (lz != STEP) begin
                        state_q <= DONE;
                    end
                end

                DONE: begin
                    if (bus.out_ready) begin
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.s         = s_q;
    assign bus.e         = e_q;
    assign bus.f         = f_q;
    assign bus.zero      = zero_q;
    assign bus.inf       = inf_q;
    assign bus.nan       = nan_q;
    assign bus.snan      = snan_q;
    assign bus.denorm    = denorm_q;

endmodule

// File: tb/tb_fp_unpack_norm.sv
module tb_fp_unpack_norm;

    localparam int S = 8;

    logic clk;
    logic rst_n;

    fp_unpack_norm_if bus ();

    fp_unpack_norm #(.SHIFT_STEP(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flags = {zero, inf, nan, snan, denorm}
    typedef struct {
        logic        db;
        logic [63:0] fp;
        logic        s;
        logic [12:0] e;
        logic [52:0] f;
        logic [4:0]  flags;
        int          lat;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: IEEE decode from the format rules, denormal normalized by
    // counting the bit distance to the leading one directly.
    function automatic vec_t model(input logic d, input logic [63:0] x);
        vec_t        r;
        int          bias;
        int          emax;
        int          ex;
        int          eint;
        int          k;
        logic [51:0] frac;
        logic [52:0] m;
        bias = d ? 1023 : 127;
        emax = d ? 2047 : 255;
        ex   = d ? int'(x[62:52]) : int'(x[30:23]);
        frac = d ? x[51:0] : {x[22:0], 29'b0};
        r.db = d;
        r.fp = x;
        r.s  = d ? x[63] : x[31];
        r.flags = 5'b0;
        r.lat   = 1;
        eint    = 0;
        r.f     = 53'd0;
        if (ex == 0 && frac == 0) begin
            r.flags = 5'b10000;
        end else if (ex == emax) begin
            r.f = {1'b0, frac};
            if (frac == 0) r.flags = 5'b01000;
            else           r.flags = {2'b00, 1'b1, ~frac[51], 1'b0};
        end else if (ex == 0) begin
`ifdef UNPACK_FTZ_EN
            r.flags = 5'b10001;
`else
            k = 52;
            for (int b = 51; b >= 0; b--) begin
                if (frac[b]) begin
                    k = 52 - b;
                    break;
                end
            end
            m = {1'b0, frac};
            r.f   = m << k;
            eint  = 1 - bias - k;
            r.flags = 5'b00001;
            r.lat = 2 + k / S;
`endif
        end else begin
            eint = ex - bias;
            r.f  = {1'b1, frac};
        end
        r.e = 13'(eint);
        return r;
    endfunction

    task automatic run_op(input vec_t v, input int hold, input string tag);
        int lat;
        @(negedge clk);
        chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.fp       = v.fp;
        bus.db       = v.db;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.fp       = {$urandom, $urandom};
        bus.db       = ~v.db;
        lat = 1;
        while (!bus.out_valid && lat < 80) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.out_valid) begin
            chk({tag, ".timeout"}, 64'd0, 64'd1);
            return;
        end
        chk({tag, ".lat"},   64'(lat), 64'(v.lat));
        chk({tag, ".s"},     64'(bus.s), 64'(v.s));
        chk({tag, ".e"},     64'(bus.e), 64'(v.e));
        chk({tag, ".f"},     64'(bus.f), 64'(v.f));
        chk({tag, ".flags"}, 64'({bus.zero, bus.inf, bus.nan, bus.snan, bus.denorm}), 64'(v.flags));
        repeat (hold) @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, ".out_valid_clr"}, 64'(bus.out_valid), 64'd0);
        chk({tag, ".in_ready_ret"},  64'(bus.in_ready),  64'd1);
    endtask

    vec_t tbl[10];
    vec_t v;
    vec_t one;
    logic [12:0] e_hold;
    logic [52:0] f_hold;
    logic        s_hold;

    initial begin
        // db fp s e f flags lat
        tbl[0] = '{1'b1, 64'h3FF0000000000000, 1'b0, 13'h0000, 53'h10000000000000, 5'b00000, 1};
        tbl[1] = '{1'b0, 64'h00000000C0400000, 1'b1, 13'h0001, 53'h18000000000000, 5'b00000, 1};
        tbl[2] = '{1'b1, 64'h7FF0000000000001, 1'b0, 13'h0000, 53'h00000000000001, 5'b00110, 1};
        tbl[3] = '{1'b1, 64'h7FF8000000000000, 1'b0, 13'h0000, 53'h08000000000000, 5'b00100, 1};
        tbl[4] = '{1'b1, 64'hFFF0000000000000, 1'b1, 13'h0000, 53'h00000000000000, 5'b01000, 1};
        tbl[5] = '{1'b1, 64'h8000000000000000, 1'b1, 13'h0000, 53'h00000000000000, 5'b10000, 1};
        tbl[6] = '{1'b0, 64'h000000007F800001, 1'b0, 13'h0000, 53'h00000020000000, 5'b00110, 1};
`ifdef UNPACK_FTZ_EN
        tbl[7] = '{1'b1, 64'h0000000000000001, 1'b0, 13'h0000, 53'h00000000000000, 5'b10001, 1};
        tbl[8] = '{1'b0, 64'h0000000000000001, 1'b0, 13'h0000, 53'h00000000000000, 5'b10001, 1};
        tbl[9] = '{1'b1, 64'h800FFFFFFFFFFFFF, 1'b1, 13'h0000, 53'h00000000000000, 5'b10001, 1};
`else
        tbl[7] = '{1'b1, 64'h0000000000000001, 1'b0, 13'h1BCE, 53'h10000000000000, 5'b00001, 8};
        tbl[8] = '{1'b0, 64'h0000000000000001, 1'b0, 13'h1F6B, 53'h10000000000000, 5'b00001, 4};
        tbl[9] = '{1'b1, 64'h800FFFFFFFFFFFFF, 1'b1, 13'h1C01, 53'h1FFFFFFFFFFFFE, 5'b00001, 2};
`endif
        one = tbl[0];

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.fp        = 64'd0;
        bus.db        = 1'b0;
        rst_n         = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.in_ready",  64'(bus.in_ready),  64'd1);
        chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst.data", 64'({bus.s, bus.e, bus.f} == '0), 64'd1);
        chk("rst.flags", 64'({bus.zero, bus.inf, bus.nan, bus.snan, bus.denorm}), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i], i % 3, $sformatf("tbl%0d", i));
        end

        // Backpressure: result must hold and no new operand may be taken.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.fp = tbl[1].fp;
        bus.db = 1'b0;
        @(negedge clk);
        bus.fp = tbl[0].fp;
        bus.db = 1'b1;
        chk("bp.out_valid", 64'(bus.out_valid), 64'd1);
        s_hold = 1'b1;
        e_hold = 13'h0001;
        f_hold = 53'h18000000000000;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("bp.hold%0d", c),
                64'({bus.out_valid, bus.in_ready, bus.s, bus.e == e_hold, bus.f == f_hold}),
                64'({1'b1, 1'b0, s_hold, 1'b1, 1'b1}));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("bp.in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        chk("bp.no_accept", 64'(bus.out_valid), 64'd0);

`ifndef UNPACK_FTZ_EN
        // Reset during the third NORM cycle of the smallest denormal.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.fp = 64'h0000000000000001;
        bus.db = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstnorm.out_valid", 64'(bus.out_valid), 64'd0);
        chk("rstnorm.in_ready",  64'(bus.in_ready),  64'd1);
        chk("rstnorm.denorm",    64'(bus.denorm),    64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(one, 0, "rstnorm.next");
`endif

        // Randomized operands against the reference model.
        for (int n = 0; n < 150; n++) begin
            logic        d;
            logic [63:0] x;
            logic [51:0] fr;
            int          cls;
            d   = 1'($urandom);
            cls = int'($urandom_range(0, 5));
            fr  = {$urandom, $urandom} >> $urandom_range(0, 51);
            if (fr == 0) fr = 52'd1;
            x = {$urandom, $urandom};
            if (d) begin
                case (cls)
                    1: x[62:0] = 63'd0;
                    2: x[62:0] = {11'h7FF, 52'd0};
                    3: x[62:0] = {11'h7FF, fr};
                    4: x[62:0] = {11'h000, fr};
                    default: ;
                endcase
            end else begin
                x[63:32] = $urandom;
                case (cls)
                    1: x[30:0] = 31'd0;
                    2: x[30:0] = {8'hFF, 23'd0};
                    3: x[30:0] = {8'hFF, (fr[22:0] == 0) ? 23'd1 : fr[22:0]};
                    4: x[30:0] = {8'h00, (fr[22:0] == 0) ? 23'd1 : fr[22:0]};
                    default: ;
                endcase
            end
            v = model(d, x);
            run_op(v, int'($urandom_range(0, 2)), $sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
